i2s_transceiver: RTL and testbench



---
 rtl/sample_pkg.sv | 16 +
 rtl/i2s_timing.sv | 43 ++++
 rtl/i2s_transceiver.sv | 124 ++++++++++++
 tb/tb_i2s_transceiver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared types and frame constants for the I2S transceiver slice.
// A frame is 64 sclk slots of 4 mclk each, so the timing counter needs 8 bits.
package sample_pkg;

    localparam int SAMPLE_WIDTH   = 24;
    localparam int MCLK_PER_SCLK  = 4;
    localparam int SCLK_PER_FRAME = 64;
    localparam int CNT_WIDTH      = $clog2(MCLK_PER_SCLK * SCLK_PER_FRAME);
    localparam int SLOT_WIDTH     = 5;

    typedef struct packed {
        logic signed [SAMPLE_WIDTH-1:0] l;
        logic signed [SAMPLE_WIDTH-1:0] r;
    } sample_t;

endpackage

// File: rtl/i2s_timing.sv
// Free-running mclk counter that defines sclk, lrck, slot index and edge strobes.
// Strobes fire in the mclk cycle before the corresponding sclk edge appears on the pins.
module i2s_timing
    import sample_pkg::*;
(
    input  logic                  mclk_i,
    input  logic                  rst_i,
    output logic                  sclk_o,
    output logic                  lrck_o,
    output logic [SLOT_WIDTH-1:0] slot_o,
    output logic [SLOT_WIDTH-1:0] nextSlot_o,
    output logic                  nextLrck_o,
    output logic                  sclkRise_o,
    output logic                  sclkFall_o,
    output logic                  frameStart_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Serial clocks come straight from register bits so they cannot glitch.
    assign sclk_o       = cnt_q[1];
    assign lrck_o       = cnt_q[CNT_WIDTH-1];
    assign slot_o       = cnt_q[6:2];
    assign nextSlot_o   = cnt_d[6:2];
    assign nextLrck_o   = cnt_d[CNT_WIDTH-1];
    assign sclkRise_o   = (cnt_q[1:0] == 2'b01);
    assign sclkFall_o   = (cnt_q[1:0] == 2'b11);
    assign frameStart_o = &cnt_q;

endmodule

// File: rtl/i2s_transceiver.sv
// Full-duplex I2S master: deserialises sdi into stereo frames and serialises
// held tx frames onto sdo, with one sclk of delay after every lrck transition.
module i2s_transceiver
    import sample_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic    mclk,
    input  logic    rst,
    output sample_t rx_data,
    output logic    rx_vld,
    input  sample_t tx_data,
    input  logic    tx_vld,
    output logic    lrck,
    output logic    sclk,
    input  logic    sdi,
    output logic    sdo
);

    logic [SLOT_WIDTH-1:0] slot;
    logic [SLOT_WIDTH-1:0] nextSlot;
    logic                  nextLrck;
    logic                  sclkRise;
    logic                  sclkFall;
    logic                  frameStart;
    logic                  rxInSlot;
    logic                  txInSlot;

    logic [DATA_WIDTH-1:0] rxL_q, rxL_d;
    logic [DATA_WIDTH-1:0] rxR_q, rxR_d;
    logic                  lastBit_q, lastBit_d;
    sample_t               rxData_q, rxData_d;
    logic                  rxVld_q, rxVld_d;
    sample_t               txHold_q, txHold_d;
    logic [DATA_WIDTH-1:0] txL_q, txL_d;
    logic [DATA_WIDTH-1:0] txR_q, txR_d;
    logic                  sdo_q, sdo_d;

    i2s_timing uTiming (
        .mclk_i       (mclk),
        .rst_i        (rst),
        .sclk_o       (sclk),
        .lrck_o       (lrck),
        .slot_o       (slot),
        .nextSlot_o   (nextSlot),
        .nextLrck_o   (nextLrck),
        .sclkRise_o   (sclkRise),
        .sclkFall_o   (sclkFall),
        .frameStart_o (frameStart)
    );

    assign rxInSlot = (slot != '0) && (slot <= SLOT_WIDTH'(DATA_WIDTH));
    assign txInSlot = (nextSlot != '0) && (nextSlot <= SLOT_WIDTH'(DATA_WIDTH));

    always_comb begin
        rxL_d     = rxL_q;
        rxR_d     = rxR_q;
        lastBit_d = 1'b0;
        rxData_d  = rxData_q;
        rxVld_d   = lastBit_q;
        if (lastBit_q) begin
            rxData_d.l = SAMPLE_WIDTH'(rxL_q);
            rxData_d.r = SAMPLE_WIDTH'(rxR_q);
        end
        if (sclkRise && rxInSlot) begin
            if (lrck) begin
                rxR_d = {rxR_q[DATA_WIDTH-2:0], sdi};
            end else begin
                rxL_d = {rxL_q[DATA_WIDTH-2:0], sdi};
            end
            lastBit_d = lrck && (slot == SLOT_WIDTH'(DATA_WIDTH));
        end
    end

    // Using txHold_d at frame start gives a same-cycle tx_vld priority over the held frame.
    always_comb begin
        txHold_d = tx_vld ? tx_data : txHold_q;
        txL_d    = txL_q;
        txR_d    = txR_q;
        sdo_d    = sdo_q;
        if (sclkFall) begin
            sdo_d = 1'b0;
            if (frameStart) begin
                txL_d = DATA_WIDTH'(txHold_d.l);
                txR_d = DATA_WIDTH'(txHold_d.r);
            end else if (txInSlot) begin
                if (nextLrck) begin
                    {sdo_d, txR_d} = {txR_q, 1'b0};
                end else begin
                    {sdo_d, txL_d} = {txL_q, 1'b0};
                end
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            rxL_q     <= '0;
            rxR_q     <= '0;
            lastBit_q <= 1'b0;
            rxData_q  <= '0;
            rxVld_q   <= 1'b0;
            txHold_q  <= '0;
            txL_q     <= '0;
            txR_q     <= '0;
            sdo_q     <= 1'b0;
        end else begin
            rxL_q     <= rxL_d;
            rxR_q     <= rxR_d;
            lastBit_q <= lastBit_d;
            rxData_q  <= rxData_d;
            rxVld_q   <= rxVld_d;
            txHold_q  <= txHold_d;
            txL_q     <= txL_d;
            txR_q     <= txR_d;
            sdo_q     <= sdo_d;
        end
    end

    assign rx_data = rxData_q;
    assign rx_vld  = rxVld_q;
    assign sdo     = sdo_q;

endmodule

// File: tb/tb_i2s_transceiver.sv
// Scoreboard bench for i2s_transceiver: sdi frames and tx writes push expectations,
// rx_vld pulses and completed sdo frames pop and compare them.
module tb_i2s_transceiver;
    import sample_pkg::*;

    localparam int DW = 24;
    // Right slot DW is sampled while cnt = 128 + 4*DW + 1; rx_data is loaded one edge later.
    localparam int RX_VLD_CNT = 128 + 4 * DW + 3;

    typedef struct {
        bit          isPattern;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } rxStim_t;

    logic    mclk = 1'b0;
    logic    rst = 1'b1;
    sample_t rxData;
    logic    rxVld;
    sample_t txDataDrv = '0;
    logic    txVldDrv = 1'b0;
    sample_t txDataPort;
    logic    txVldPort;
    logic    lrck;
    logic    sclk;
    logic    sdi = 1'b0;
    logic    sdo;
    logic    loopback = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0]  tbCnt = 8'd0;
    logic [31:0] sdiWordL = '0;
    logic [31:0] sdiWordR = '0;
    sample_t     curRxExp = '0;
    sample_t     heldModel = '0;
    logic [63:0] capSdo = '0;
    int          vldInFrame = 0;

    rxStim_t     rxStimQ[$];
    sample_t     expRxQ[$];
    logic [63:0] expTxQ[$];

    assign txDataPort = loopback ? rxData : txDataDrv;
    assign txVldPort  = loopback ? rxVld : txVldDrv;

    always #5 mclk = ~mclk;

    i2s_transceiver #(.DATA_WIDTH(DW)) dut (
        .mclk    (mclk),
        .rst     (rst),
        .rx_data (rxData),
        .rx_vld  (rxVld),
        .tx_data (txDataPort),
        .tx_vld  (txVldPort),
        .lrck    (lrck),
        .sclk    (sclk),
        .sdi     (sdi),
        .sdo     (sdo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] patternWord();
        logic [7:0]  pat = 8'b10100101;
        logic [31:0] w;
        for (int s = 0; s < 32; s++) w[31-s] = pat[7-(s%8)];
        return w;
    endfunction

    function automatic logic [63:0] sdoFrame(input sample_t s);
        return {1'b0, s.l, 7'b0, 1'b0, s.r, 7'b0};
    endfunction

    // Independent frame position counter, reset exactly like the DUT.
    always @(posedge mclk) tbCnt <= rst ? 8'd0 : tbCnt + 8'd1;

    // Codec-side ADC: new bit just after each sclk falling edge.
    always @(posedge mclk) begin
        #2;
        if (rst) begin
            expRxQ.delete();
            sdi = 1'b0;
        end else begin
            if (tbCnt == 8'd0) begin
                rxStim_t st;
                if (rxStimQ.size() > 0) st = rxStimQ.pop_front();
                else st = '{isPattern: 1'b0, l: '0, r: '0};
                if (st.isPattern) begin
                    sdiWordL = patternWord();
                    sdiWordR = patternWord();
                    curRxExp = {24'h4B4B4B, 24'h4B4B4B};
                end else begin
                    sdiWordL = {1'b1, st.l, 7'b0110101};
                    sdiWordR = {1'b0, st.r, 7'b1001011};
                    curRxExp = {st.l, st.r};
                end
                expRxQ.push_back(curRxExp);
            end
            if (tbCnt[1:0] == 2'd0)
                sdi = tbCnt[7] ? sdiWordR[31 - tbCnt[6:2]] : sdiWordL[31 - tbCnt[6:2]];
        end
    end

    // Expected sdo frame decided at the frame-start edge.
    always @(posedge mclk) begin
        if (rst) begin
            heldModel <= '0;
            expTxQ.delete();
            expTxQ.push_back(64'd0);
        end else begin
            if (txVldDrv) heldModel <= txDataDrv;
            if (tbCnt == 8'd255) begin
                sample_t nxt;
                nxt = loopback ? curRxExp : (txVldDrv ? txDataDrv : heldModel);
                expTxQ.push_back(sdoFrame(nxt));
            end
        end
    end

    always @(negedge mclk) begin
        checkOutput("lrckSclk", {62'd0, lrck, sclk}, {62'd0, tbCnt[7], tbCnt[1]});
        if (rst) vldInFrame = 0;
        if (rxVld) begin
            vldInFrame++;
            checkOutput("rxVldPos", {56'd0, tbCnt}, 64'(RX_VLD_CNT));
            if (expRxQ.size() == 0) checkOutput("rxVldUnexpected", 64'd1, 64'd0);
            else checkOutput("rxData", rxData, expRxQ.pop_front());
        end
        if (tbCnt[1:0] == 2'd2) capSdo[63 - {tbCnt[7], tbCnt[6:2]}] = sdo;
        if (tbCnt == 8'd255 && !rst) begin
            checkOutput("rxVldPerFrame", 64'(vldInFrame), 64'd1);
            vldInFrame = 0;
            if (expTxQ.size() == 0) checkOutput("sdoNoExpect", 64'd1, 64'd0);
            else checkOutput("sdoFrame", capSdo, expTxQ.pop_front());
        end
    end

    task automatic waitCnt(input logic [7:0] v);
        for (int i = 0; i < 600; i++) begin
            @(posedge mclk);
            #1;
            if (tbCnt == v) return;
        end
        checkOutput("waitCnt", {56'd0, tbCnt}, {56'd0, v});
    endtask

    task automatic applyStimulus(input sample_t v);
        txDataDrv = v;
        txVldDrv  = 1'b1;
        @(posedge mclk);
        #1;
        txVldDrv  = 1'b0;
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, "Sdo"}, {63'd0, sdo}, 64'd0);
        checkOutput({phase, "Sclk"}, {63'd0, sclk}, 64'd0);
        checkOutput({phase, "Lrck"}, {63'd0, lrck}, 64'd0);
        checkOutput({phase, "RxVld"}, {63'd0, rxVld}, 64'd0);
        checkOutput({phase, "RxData"}, rxData, 64'd0);
    endtask

    initial begin
        repeat (4) @(posedge mclk);
        @(negedge mclk);
        checkAllZero("reset");

        rxStimQ.push_back('{isPattern: 1'b0, l: 24'hA5A5A5, r: 24'h5A5A5A});
        rxStimQ.push_back('{isPattern: 1'b0, l: 24'hA5A5A5, r: 24'h5A5A5A});
        rxStimQ.push_back('{isPattern: 1'b1, l: '0, r: '0});
        rxStimQ.push_back('{isPattern: 1'b1, l: '0, r: '0});
        rxStimQ.push_back('{isPattern: 1'b0, l: 24'($urandom()), r: 24'($urandom())});
        @(posedge mclk);
        #1;
        rst = 1'b0;

        // Single write, then repeated with no further tx_vld.
        waitCnt(8'd50);
        applyStimulus({24'h800001, 24'h7FFFFE});
        repeat (3) waitCnt(8'd255);

        // Latest write wins, and a write at the frame-start edge bypasses the holding register.
        waitCnt(8'd60);
        applyStimulus({24'($urandom()), 24'($urandom())});
        waitCnt(8'd255);
        applyStimulus({24'($urandom()), 24'($urandom())});
        repeat (2) waitCnt(8'd255);

        // Reset in the middle of the right channel.
        waitCnt(8'd150);
        rst = 1'b1;
        @(posedge mclk);
        @(negedge mclk);
        checkAllZero("midReset");
        for (int i = 0; i < 4; i++)
            rxStimQ.push_back('{isPattern: 1'b0, l: 24'($urandom()), r: 24'($urandom())});
        @(posedge mclk);
        #1;
        rst = 1'b0;

        waitCnt(8'd10);
        loopback = 1'b1;
        repeat (5) waitCnt(8'd255);
        @(negedge mclk);
        @(negedge mclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
